// File: rtl/fill_rect_cmd_parser_pkg.sv
// Shared definitions for the fill-rect command path: opcode, payload slot
// layout and the command word width used by both parser and engine.
package fill_rect_cmd_parser_pkg;

    localparam logic [7:0] OPCODE_FILL_DEF = 8'h01;

    // Command word: byte k lives at bits [8k+7:8k]
    localparam int CMD_W     = 88;
    localparam int CMD_BYTES = CMD_W / 8;

    // Payload slot offsets (16-bit fields are sent high byte first)
    localparam int SLOT_ORIGX_HI = 0;
    localparam int SLOT_ORIGX_LO = 1;
    localparam int SLOT_ORIGY_HI = 2;
    localparam int SLOT_ORIGY_LO = 3;
    localparam int SLOT_WID_HI   = 4;
    localparam int SLOT_WID_LO   = 5;
    localparam int SLOT_HGT_HI   = 6;
    localparam int SLOT_HGT_LO   = 7;
    localparam int SLOT_R        = 8;
    localparam int SLOT_G        = 9;
    localparam int SLOT_B        = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HOLD    = 2'd2
    } parser_state_e;

    // Reassemble a 16-bit field whose high byte sits in slot hi_slot
    function automatic logic [15:0] cmd_field(input logic [CMD_W-1:0] cmd,
                                              input int hi_slot);
        return {cmd[8*hi_slot +: 8], cmd[8*(hi_slot+1) +: 8]};
    endfunction

endpackage

// File: rtl/fill_rect_cmd_parser_sat_counter.sv
// 8-bit event counter that sticks at all-ones instead of wrapping.
module fill_rect_cmd_parser_sat_counter (
    input  logic       clk,
    input  logic       rst_,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Step on each event until the count reaches 8'hFF
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fill_rect_cmd_parser.sv
// Byte-stream parser for fill-rect commands. Collects the 11 payload bytes
// after an opcode, drops garbage, stalled and zero-area commands (counting
// each drop), and holds the assembled word on out_rts/out_rtr.
//
// Handshake: a byte moves when in_rts & in_rtr on a rising edge; a command
// moves when out_rts & out_rtr on a rising edge. in_rtr decodes state only,
// so there is no combinational path from out_rtr back to the byte source.
module fill_rect_cmd_parser
    import fill_rect_cmd_parser_pkg::*;
#(
    parameter logic [7:0] OPCODE_FILL = OPCODE_FILL_DEF,
    parameter int         TIMEOUT     = 1024,
    parameter bit         DROP_EMPTY  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [7:0]       in_data,
    input  logic             in_rts,
    output logic             in_rtr,
    output logic [CMD_W-1:0] out_data,
    output logic             out_rts,
    input  logic             out_rtr,
    output logic [7:0]       err_cnt,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int             TO_W     = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]     LAST_IDX = 4'(CMD_BYTES - 1);

    parser_state_e       state_q;
    logic [3:0]          idx_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic [CMD_W-9:0]    payload_q;   // bytes 0..9; byte 10 joins on the final edge
    logic [CMD_W-1:0]    out_data_q;
    logic                out_rts_q;

    logic                in_fire;
    logic                last_byte;
    logic                is_empty;
    logic                timed_out;
    logic                err_inc;

    // Handshake and error-event decode; wid/hgt bytes are already registered by idx 10
    always_comb begin
        in_fire   = in_rts && in_rtr;
        last_byte = (state_q == ST_PAYLOAD) && in_fire && (idx_q == LAST_IDX);
        is_empty  = DROP_EMPTY &&
                    ((cmd_field({8'h00, payload_q}, SLOT_WID_HI) == 16'h0000) ||
                     (cmd_field({8'h00, payload_q}, SLOT_HGT_HI) == 16'h0000));
        timed_out = (state_q == ST_PAYLOAD) && !in_fire && (to_cnt_q == TO_LAST);
        err_inc   = ((state_q == ST_IDLE) && in_fire && (in_data != OPCODE_FILL)) ||
                    (last_byte && is_empty) ||
                    timed_out;
    end

    // Parser FSM with registered command outputs
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            to_cnt_q   <= '0;
            payload_q  <= '0;
            out_data_q <= '0;
            out_rts_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_fire && (in_data == OPCODE_FILL)) begin
                        idx_q    <= 4'd0;
                        to_cnt_q <= '0;
                        state_q  <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_fire) begin
                        to_cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            idx_q <= 4'd0;
                            if (is_empty) begin
                                state_q <= ST_IDLE;
                            end else begin
                                out_data_q <= {in_data, payload_q};
                                out_rts_q  <= 1'b1;
                                state_q    <= ST_HOLD;
                            end
                        end else begin
                            payload_q[{idx_q, 3'b000} +: 8] <= in_data;
                            idx_q <= idx_q + 4'd1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        payload_q <= '0;
                        idx_q     <= 4'd0;
                        state_q   <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_rtr) begin
                        out_rts_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    fill_rect_cmd_parser_sat_counter u_err_cnt (
        .clk   (clk),
        .rst_  (rst_),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    assign in_rtr    = (state_q != ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign out_rts   = out_rts_q;
    assign out_data  = out_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fill_rect_cmd_parser.sv
// Directed + randomized bench for fill_rect_cmd_parser. A second instance
// with DROP_EMPTY=0 shares the inputs and is only observed in the
// zero-area step.
module tb_fill_rect_cmd_parser;
  import fill_rect_cmd_parser_pkg::*;

  localparam int TIMEOUT = 1024;
  localparam logic [7:0] OP = 8'h01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]       in_data = 8'h00;
  logic             in_rts = 1'b0;
  logic             out_rtr = 1'b1;
  logic             in_rtr, out_rts, busy;
  logic [CMD_W-1:0] out_data;
  logic [7:0]       err_cnt;
  logic [1:0]       dbg_state;
  logic             k_in_rtr, k_out_rts, k_busy;
  logic [CMD_W-1:0] k_out_data;
  logic [7:0]       k_err_cnt;
  logic [1:0]       k_dbg_state;

  fill_rect_cmd_parser #(.OPCODE_FILL(OP), .TIMEOUT(TIMEOUT), .DROP_EMPTY(1'b1)) dut (
    .clk(clk), .rst_(rst_), .in_data(in_data), .in_rts(in_rts), .in_rtr(in_rtr),
    .out_data(out_data), .out_rts(out_rts), .out_rtr(out_rtr),
    .err_cnt(err_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  fill_rect_cmd_parser #(.OPCODE_FILL(OP), .TIMEOUT(TIMEOUT), .DROP_EMPTY(1'b0)) dut_keep (
    .clk(clk), .rst_(rst_), .in_data(in_data), .in_rts(in_rts), .in_rtr(k_in_rtr),
    .out_data(k_out_data), .out_rts(k_out_rts), .out_rtr(out_rtr),
    .err_cnt(k_err_cnt), .busy(k_busy), .dbg_state(k_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [CMD_W-1:0] exp_q[$];
  int exp_err = 0;
  bit rand_rtr = 1'b0;

  task automatic check_word(input string tag, input logic [CMD_W-1:0] obs, input logic [CMD_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Every command handed to the engine must be the oldest expected one
  always begin
    @(negedge clk);
    #1;
    if (rst_ && out_rts && out_rtr) begin
      check_bit("cmd_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check_word("cmd_data", out_data, exp_q.pop_front());
    end
  end

  // ---------------- reference helpers ----------------
  // Field-level construction of the command word, byte 0 = origx high byte
  function automatic logic [CMD_W-1:0] make_cmd(input logic [15:0] ox, input logic [15:0] oy,
                                                input logic [15:0] w, input logic [15:0] h,
                                                input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b);
    return {b, g, r, h[7:0], h[15:8], w[7:0], w[15:8], oy[7:0], oy[15:8], ox[7:0], ox[15:8]};
  endfunction

  function automatic logic [CMD_W-1:0] rand_cmd();
    return make_cmd(16'($urandom), 16'($urandom), 16'($urandom_range(1, 65535)),
                    16'($urandom_range(1, 65535)), 8'($urandom), 8'($urandom), 8'($urandom));
  endfunction

  function automatic logic [7:0] rand_garbage();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == OP) b = 8'hA5;
    return b;
  endfunction

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data = b;
    in_rts = 1'b1;
    while (!in_rtr && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited == 200) check_bit("in_rtr_wait", in_rtr, 1'b1);
    @(negedge clk);
    in_rts = 1'b0;
  endtask

  task automatic send_payload(input logic [CMD_W-1:0] cmd);
    for (int k = 0; k < CMD_BYTES; k++) send_byte(cmd[8*k +: 8]);
  endtask

  task automatic send_cmd(input logic [CMD_W-1:0] cmd, input bit expect_issue);
    if (expect_issue) exp_q.push_back(cmd);
    send_byte(OP);
    send_payload(cmd);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_word("queue_drained", CMD_W'(exp_q.size()), '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [CMD_W-1:0] c, c2, zc;
    logic [7:0] rs[$];
    int i;

    // Reset state
    #12;
    check_bit("rst_in_rtr", in_rtr, 1'b1);
    check_bit("rst_out_rts", out_rts, 1'b0);
    check_word("rst_out_data", out_data, '0);
    check_byte("rst_err_cnt", err_cnt, 8'h00);
    check_bit("rst_busy", busy, 1'b0);
    check_byte("rst_state", 8'(dbg_state), 8'(ST_IDLE));
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);

    // Nominal command, one-cycle out_rts, exact word
    out_rtr = 1'b1;
    c = 88'h0A_00_0F_04_00_08_00_20_00_10_00;
    exp_q.push_back(c);
    send_byte(OP);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h0F); send_byte(8'h00); send_byte(8'h0A);
    check_bit("nom_out_rts_set", out_rts, 1'b1);
    check_word("nom_out_data", out_data, c);
    @(negedge clk);
    check_bit("nom_out_rts_clr", out_rts, 1'b0);
    check_word("nom_data_held", out_data, c);
    check_byte("nom_err_cnt", err_cnt, 8'(exp_err));

    // Garbage then a valid command
    send_byte(8'h55);
    send_byte(8'hAA);
    exp_err += 2;
    check_byte("garbage_err_cnt", err_cnt, 8'(exp_err));
    send_cmd(rand_cmd(), 1'b1);
    drain();

    // Backpressure: hold 20 cycles while the next opcode is offered
    out_rtr = 1'b0;
    c = rand_cmd();
    send_cmd(c, 1'b1);
    in_data = OP;
    in_rts = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check_bit("bp_in_rtr", in_rtr, 1'b0);
      check_bit("bp_out_rts", out_rts, 1'b1);
      check_word("bp_out_data", out_data, c);
      @(negedge clk);
    end
    out_rtr = 1'b1;
    @(negedge clk);
    check_bit("bp_idle_after_xfer", busy, 1'b0);
    @(negedge clk);
    check_bit("bp_opcode_taken", busy, 1'b1);
    in_rts = 1'b0;
    c2 = rand_cmd();
    exp_q.push_back(c2);
    send_payload(c2);
    drain();

    // Timeout: opcode + 5 bytes then silence
    send_byte(OP);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    for (int k = 0; k < TIMEOUT - 1; k++) @(negedge clk);
    check_bit("to_busy_before", busy, 1'b1);
    check_byte("to_err_before", err_cnt, 8'(exp_err));
    @(negedge clk);
    check_bit("to_busy_after", busy, 1'b0);
    exp_err += 1;
    check_byte("to_err_cnt", err_cnt, 8'(exp_err));
    send_cmd(rand_cmd(), 1'b1);
    drain();

    // Zero area: width 0, then height 0
    zc = make_cmd(16'($urandom), 16'($urandom), 16'h0000, 16'h0033, 8'h12, 8'h34, 8'h56);
    send_cmd(zc, 1'b0);
    check_bit("zw_drop_no_rts", out_rts, 1'b0);
    check_bit("zw_keep_rts", k_out_rts, 1'b1);
    check_word("zw_keep_data", k_out_data, zc);
    check_byte("zw_keep_err", k_err_cnt, 8'(exp_err));
    exp_err += 1;
    check_byte("zw_drop_err", err_cnt, 8'(exp_err));
    @(negedge clk);
    @(negedge clk);
    zc = make_cmd(16'($urandom), 16'($urandom), 16'h0100, 16'h0000, 8'h9A, 8'hBC, 8'hDE);
    send_cmd(zc, 1'b0);
    check_bit("zh_drop_no_rts", out_rts, 1'b0);
    check_bit("zh_keep_rts", k_out_rts, 1'b1);
    check_word("zh_keep_data", k_out_data, zc);
    exp_err += 1;
    check_byte("zh_drop_err", err_cnt, 8'(exp_err));
    @(negedge clk);
    @(negedge clk);

    // Random stream against the stream-level model
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        rs.push_back(rand_garbage());
      end else begin
        c = rand_cmd();
        case ($urandom_range(0, 5))
          0: c[47:32] = 16'h0000;
          1: c[63:48] = 16'h0000;
          default: ;
        endcase
        rs.push_back(OP);
        for (int k = 0; k < CMD_BYTES; k++) rs.push_back(c[8*k +: 8]);
      end
    end
    i = 0;
    while (i < rs.size()) begin
      if (rs[i] != OP) begin
        exp_err++;
        i++;
      end else begin
        for (int k = 0; k < CMD_BYTES; k++) c[8*k +: 8] = rs[i + 1 + k];
        if (c[47:32] == 16'h0000 || c[63:48] == 16'h0000) exp_err++;
        else exp_q.push_back(c);
        i += CMD_BYTES + 1;
      end
    end
    rand_rtr = 1'b1;
    fork
      begin
        while (rand_rtr) begin
          @(negedge clk);
          if (rand_rtr) out_rtr = 1'($urandom_range(0, 1));
        end
      end
    join_none
    foreach (rs[j]) begin
      send_byte(rs[j]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rtr = 1'b0;
    out_rtr = 1'b1;
    drain();
    check_byte("rand_err_cnt", err_cnt, 8'(exp_err));

    // Saturation: 300 invalid bytes
    for (int n = 0; n < 300; n++) begin
      send_byte(rand_garbage());
      if (exp_err < 255) exp_err++;
      check_byte("sat_err_cnt", err_cnt, 8'(exp_err));
    end
    check_byte("sat_final", err_cnt, 8'hFF);

    // Asynchronous reset mid-payload
    send_byte(OP);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    #3;
    rst_ = 1'b0;
    #1;
    check_bit("rp_in_rtr", in_rtr, 1'b1);
    check_bit("rp_out_rts", out_rts, 1'b0);
    check_word("rp_out_data", out_data, '0);
    check_byte("rp_err_cnt", err_cnt, 8'h00);
    check_bit("rp_busy", busy, 1'b0);
    @(negedge clk);
    rst_ = 1'b1;
    exp_err = 0;
    @(negedge clk);

    // Asynchronous reset mid-hold
    out_rtr = 1'b0;
    send_cmd(rand_cmd(), 1'b0);
    check_bit("rh_holding", out_rts, 1'b1);
    #2;
    rst_ = 1'b0;
    #1;
    check_bit("rh_out_rts", out_rts, 1'b0);
    check_word("rh_out_data", out_data, '0);
    check_bit("rh_in_rtr", in_rtr, 1'b1);
    check_bit("rh_busy", busy, 1'b0);
    check_byte("rh_err_cnt", err_cnt, 8'h00);
    @(negedge clk);
    rst_ = 1'b1;
    out_rtr = 1'b1;
    @(negedge clk);

    // Clean command after reset
    send_cmd(rand_cmd(), 1'b1);
    drain();
    check_byte("post_rst_err_cnt", err_cnt, 8'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
